id_ex_stage: RTL
================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline stage directly downstream of the 32x64 register file. Registers
//  decoded operands, immediate and control for EX. Forwards EX/MEM and MEM/WB results
//  into EX operands, bypasses the same-cycle WB write into the ID read, detects
//  load-use hazards (stalls ID/IF, inserts bubble), honours branch flush, counts stalls.
// PARAMETERS
//  DATA_W    64  operand/result width
//  REG_AW    5   register index width
//  CTRL_W    8   packed EX/MEM/WB control width (layout fixed in cpu_pkg)
//  ZERO_REG  31  index of XZR; never forwarded, never a hazard source
//  CNT_W     32  stall counter width
// PORTS
//  clk             in   1       clock, all state on posedge
//  reset           in   1       asynchronous, active-low reset
//  id_valid        in   1       ID holds a real instruction
//  id_rn,id_rm     in   REG_AW  source indices driven to regfile ReadRegister1/2
//  id_rd           in   REG_AW  destination index
//  id_rd1,id_rd2   in   DATA_W  regfile ReadData1/ReadData2
//  id_imm          in   DATA_W  sign-extended immediate
//  id_ctrl         in   CTRL_W  control bundle; bits memread, regwrite per cpu_pkg
//  ex_flush        in   1       taken branch resolved; kill ID and EX content
//  exmem_rd        in   REG_AW  EX/MEM destination
//  exmem_regwrite  in   1       EX/MEM writes a register (qualified by its valid)
//  exmem_result    in   DATA_W  EX/MEM ALU result
//  memwb_rd        in   REG_AW  MEM/WB destination = regfile WriteRegister
//  memwb_regwrite  in   1       = regfile RegWrite
//  memwb_result    in   DATA_W  = regfile WriteData
//  stall_id        out  1       hold PC and IF/ID this cycle (combinational)
//  ex_valid        out  1       EX content is a real instruction
//  ex_rd           out  REG_AW  latched destination
//  ex_a,ex_b       out  DATA_W  forwarded operands for the ALU (combinational off regs)
//  ex_imm          out  DATA_W  latched immediate
//  ex_ctrl         out  CTRL_W  latched control; forced 0 when bubble
//  stall_cnt       out  CNT_W   saturating count of stall cycles
// BEHAVIOUR
//  - Reset (async assert, sync release): ex_valid=0, ex_rd=0, ex_imm=0, ex_ctrl=0,
//    latched operands=0, stall_cnt=0; stall_id=0 while reset is low.
//  - ID bypass: if memwb_regwrite && memwb_rd==id_rn && id_rn!=ZERO_REG, latch
//    memwb_result instead of id_rd1 (same for rm/id_rd2). Always present.
//  - Hazard: load_use = ex_valid && ex_ctrl.memread && ex_rd!=ZERO_REG && id_valid &&
//    (ex_rd==id_rn || ex_rd==id_rm). stall_id = hazard && !ex_flush.
//  - Update priority each posedge: ex_flush > stall_id > normal.
//    flush: ex_valid<=0, ex_ctrl<=0 (bubble). stall: ex_valid<=0, ex_ctrl<=0, ID held
//    upstream. normal: latch ID fields, ex_valid<=id_valid, ex_ctrl<=id_valid?id_ctrl:0.
//  - Latency: ID->EX one cycle; forwarding into ex_a/ex_b zero cycles.
//  - stall_cnt +1 on every posedge with stall_id=1; holds at all-ones (no wrap).
//  - Reads of ZERO_REG always yield 0 in ex_a/ex_b regardless of forwarding.
// CONFIGURATION
//  ID_EX_FORWARD_EN defined: EX forwarding, priority EX/MEM > MEM/WB > latched value,
//    match on latched rn/rm, skip ZERO_REG; hazard = load_use only.
//  Undefined: ex_a/ex_b = latched values; hazard = any RAW on id_rn/id_rm against
//    EX (ex_valid && regwrite) or EX/MEM (exmem_regwrite); ID bypass still applies.
// STRUCTURE
//  cpu_pkg: ctrl_t packed struct (aluop, alusrc, memread, memwrite, regwrite,
//    memtoreg, branch), XZR=31, DATA_W/REG_AW constants.
//  Sub-module id_ex_fwd_mux: combinational 3:1 select per operand, instantiated x2.
// TESTING
//  1 ADD X1 then SUB X2,X1,X3: exmem_rd=1,result=0x10 -> ex_a=0x10, stall_id=0 (FWD_EN).
//  2 LDUR X5 then ADD X6,X5,X5 -> stall_id=1 one cycle, bubble ex_ctrl=0, stall_cnt=1.
//  3 memwb writes X7=0xABCD while ID reads X7 -> ex_a=0xABCD next cycle.
//  4 Load-use and ex_flush same cycle -> stall_id=0, ex_valid=0, stall_cnt unchanged.
//  5 Writes/forwards to X31 (result 0xFFFF) -> ex_a=ex_b=0, no stall.
//  6 reset low mid-stall -> all outputs 0 immediately; no FWD_EN: case 1 stalls 2 cycles.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline types: packed EX/MEM/WB control bundle, XZR index and operand widths.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int REG_AW = 5;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 32;
  localparam int XZR    = 31;

  // MSB..LSB: aluop[1:0], alusrc, memread, memwrite, regwrite, memtoreg, branch
  typedef struct packed {
    logic [1:0] aluop;
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
  } ctrl_t;

  typedef enum logic [1:0] {
    FWD_LATCHED = 2'd0,
    FWD_MEMWB   = 2'd1,
    FWD_EXMEM   = 2'd2
  } fwd_sel_t;

  function automatic logic ctrl_memread(input ctrl_t c);
    return c.memread;
  endfunction

  function automatic logic ctrl_regwrite(input ctrl_t c);
    return c.regwrite;
  endfunction

endpackage

// File: rtl/id_ex_fwd_mux.sv
// One EX operand: EX/MEM > MEM/WB > latched value; reads of the zero register give 0.
module id_ex_fwd_mux
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] latched,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic [DATA_W-1:0] operand
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  fwd_sel_t sel;

  always_comb begin
    sel = FWD_LATCHED;
    if (exmem_regwrite && exmem_rd == src)
      sel = FWD_EXMEM;
    else if (memwb_regwrite && memwb_rd == src)
      sel = FWD_MEMWB;

    case (sel)
      FWD_EXMEM: operand = exmem_result;
      FWD_MEMWB: operand = memwb_result;
      default:   operand = latched;
    endcase

    if (src == ZR)
      operand = '0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ID write-back bypass, hazard stall, flush and stall counter.
// ID_EX_FORWARD_EN: enables EX/MEM and MEM/WB forwarding into EX; hazard reduces to load-use.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W   = cpu_pkg::DATA_W,
  parameter int REG_AW   = cpu_pkg::REG_AW,
  parameter int CTRL_W   = cpu_pkg::CTRL_W,
  parameter int ZERO_REG = cpu_pkg::XZR,
  parameter int CNT_W    = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rn,
  input  logic [REG_AW-1:0] id_rm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_regwrite,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic              memwb_regwrite,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [REG_AW-1:0] ZR = REG_AW'(ZERO_REG);

  logic [REG_AW-1:0] rn_q, rm_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [DATA_W-1:0] a_in, b_in;
  logic              load_use, hazard;
  logic              fwd_exmem_we, fwd_memwb_we;

  // Same-cycle regfile write is not yet visible on ReadData, so take WriteData directly.
  always_comb begin
    a_in = id_rd1;
    b_in = id_rd2;
    if (memwb_regwrite && memwb_rd == id_rn && id_rn != ZR) a_in = memwb_result;
    if (memwb_regwrite && memwb_rd == id_rm && id_rm != ZR) b_in = memwb_result;
  end

  always_comb begin
    load_use = ex_valid && ctrl_memread(ex_ctrl) && ex_rd != ZR && id_valid &&
               (ex_rd == id_rn || ex_rd == id_rm);
`ifdef ID_EX_FORWARD_EN
    hazard       = load_use;
    fwd_exmem_we = exmem_regwrite;
    fwd_memwb_we = memwb_regwrite;
`else
    hazard = load_use ||
             (id_valid && ex_valid && ctrl_regwrite(ex_ctrl) && ex_rd != ZR &&
              (ex_rd == id_rn || ex_rd == id_rm)) ||
             (id_valid && exmem_regwrite && exmem_rd != ZR &&
              (exmem_rd == id_rn || exmem_rd == id_rm));
    fwd_exmem_we = 1'b0;
    fwd_memwb_we = 1'b0;
`endif
    stall_id = reset && hazard && !ex_flush;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid  <= 1'b0;
      ex_rd     <= '0;
      ex_imm    <= '0;
      ex_ctrl   <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      stall_cnt <= '0;
    end else begin
      if (ex_flush || stall_id) begin
        ex_valid <= 1'b0;
        ex_ctrl  <= '0;
      end else begin
        ex_valid <= id_valid;
        ex_ctrl  <= id_valid ? id_ctrl : '0;
        ex_rd    <= id_rd;
        ex_imm   <= id_imm;
        rn_q     <= id_rn;
        rm_q     <= id_rm;
        a_q      <= a_in;
        b_q      <= b_in;
      end
      if (stall_id && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_a (
    .src(rn_q), .latched(a_q),
    .exmem_regwrite(fwd_exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(fwd_memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .operand(ex_a)
  );

  id_ex_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_fwd_b (
    .src(rm_q), .latched(b_q),
    .exmem_regwrite(fwd_exmem_we), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(fwd_memwb_we), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .operand(ex_b)
  );

endmodule
